// File: rtl/mem_access_stage.sv
// Memory-access stage: one data-bus transaction per instruction,
// valid/ready on both sides, registered writeback bundle.
package mem_access_pkg;
  localparam int W_OPCODE = 6;
  localparam int W_CPU = 32;

  localparam logic [W_OPCODE-1:0] OP_ADD = 6'h00;
  localparam logic [W_OPCODE-1:0] OP_SUB = 6'h01;
  localparam logic [W_OPCODE-1:0] OP_AND = 6'h02;
  localparam logic [W_OPCODE-1:0] OP_OR  = 6'h03;
  localparam logic [W_OPCODE-1:0] OP_LB  = 6'h20;
  localparam logic [W_OPCODE-1:0] OP_LH  = 6'h21;
  localparam logic [W_OPCODE-1:0] OP_LW  = 6'h23;
  localparam logic [W_OPCODE-1:0] OP_LBU = 6'h24;
  localparam logic [W_OPCODE-1:0] OP_LHU = 6'h25;
  localparam logic [W_OPCODE-1:0] OP_SB  = 6'h28;
  localparam logic [W_OPCODE-1:0] OP_SH  = 6'h29;
  localparam logic [W_OPCODE-1:0] OP_SW  = 6'h2B;
endpackage

module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int W_RADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_OPCODE-1:0] mem_op,
  input  logic [W_CPU-1:0]   alu_result,
  input  logic [W_CPU-1:0]   store_data,
  input  logic [W_RADDR-1:0] rd_in,
  output logic               bus_req,
  output logic               bus_we,
  output logic [W_CPU-1:0]   bus_addr,
  output logic [W_CPU-1:0]   bus_wdata,
  output logic [3:0]         bus_wstrb,
  input  logic               bus_ack,
  input  logic [W_CPU-1:0]   bus_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_CPU-1:0]   wb_data,
  output logic [W_RADDR-1:0] wb_rd,
  output logic               wb_en,
  output logic               mem_err
);

  localparam int W_CNT = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  state_t state, state_d;

  logic [W_CNT-1:0] cnt;
  logic [W_CPU-1:0] addr_q;
  logic [3:0] strb_q;
  logic we_q;
  logic load_q;
  logic sext_q;
  size_t sz_q;

  logic is_load, is_store, sext;
  size_t sz;
  logic misal, go_bus;
  logic accept, ack_hit, tmo;
  logic [3:0] strb_d;
  logic [W_CPU-1:0] wdata_d;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [W_CPU-1:0] ld_val;

  // Decode the incoming opcode and build lane enables / store data.
  always_comb begin
    is_load = 1'b0;
    is_store = 1'b0;
    sext = 1'b0;
    sz = SZ_W;
    unique case (mem_op)
      OP_LB:  begin is_load = 1'b1; sext = 1'b1; sz = SZ_B; end
      OP_LBU: begin is_load = 1'b1; sz = SZ_B; end
      OP_LH:  begin is_load = 1'b1; sext = 1'b1; sz = SZ_H; end
      OP_LHU: begin is_load = 1'b1; sz = SZ_H; end
      OP_LW:  begin is_load = 1'b1; sz = SZ_W; end
      OP_SB:  begin is_store = 1'b1; sz = SZ_B; end
      OP_SH:  begin is_store = 1'b1; sz = SZ_H; end
      OP_SW:  begin is_store = 1'b1; sz = SZ_W; end
      default: ;
    endcase
    misal = (sz == SZ_W && alu_result[1:0] != 2'b00)
         || (sz == SZ_H && alu_result[0]);
    go_bus = (is_load | is_store) & ~misal;
    strb_d = 4'b1111;
    wdata_d = store_data;
    unique case (sz)
      SZ_B: begin
        strb_d = 4'b0001 << alu_result[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      SZ_H: begin
        strb_d = 4'b0011 << alu_result[1:0];
        wdata_d = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick and extend the addressed lane of the read word.
  always_comb begin
    ld_byte = bus_rdata[7:0];
    unique case (addr_q[1:0])
      2'd1: ld_byte = bus_rdata[15:8];
      2'd2: ld_byte = bus_rdata[23:16];
      2'd3: ld_byte = bus_rdata[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_val = bus_rdata;
    unique case (sz_q)
      SZ_B: ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
      SZ_H: ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_d = state;
    in_ready = 1'b0;
    accept = 1'b0;
    ack_hit = 1'b0;
    tmo = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      BUS: begin
        if (bus_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt == W_CNT'(TIMEOUT - 1)) begin
          tmo = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) state_d = go_bus ? BUS : DONE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end

  // Capture the bundle, run the wait counter, fill the writeback regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      addr_q <= '0;
      strb_q <= '0;
      we_q <= 1'b0;
      load_q <= 1'b0;
      sext_q <= 1'b0;
      sz_q <= SZ_W;
      bus_wdata <= '0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_en <= 1'b0;
      mem_err <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      addr_q <= alu_result;
      strb_q <= is_store ? strb_d : 4'b0000;
      we_q <= is_store;
      load_q <= is_load;
      sext_q <= sext;
      sz_q <= sz;
      bus_wdata <= wdata_d;
      wb_rd <= rd_in;
      if (!(is_load | is_store)) begin
        wb_data <= alu_result;
        wb_en <= (rd_in != '0);
        mem_err <= 1'b0;
      end else begin
        wb_data <= '0;
        wb_en <= 1'b0;
        mem_err <= misal;
      end
    end else if (ack_hit) begin
      if (load_q) begin
        wb_data <= ld_val;
        wb_en <= (wb_rd != '0);
      end
    end else if (tmo) begin
      mem_err <= 1'b1;
      wb_en <= 1'b0;
    end else if (state == BUS) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_valid = (state == DONE);
  assign bus_req = (state == BUS);
  assign bus_we = bus_req & we_q;
  assign bus_wstrb = bus_req ? strb_q : 4'b0000;
  assign bus_addr = {addr_q[W_CPU-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads,
// stores, misalignment, timeout, stall, back-to-back and reset.
module tb_mem_access_stage;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [W_OPCODE-1:0] mem_op;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0] rd_in;
  logic bus_req;
  logic bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0] bus_wstrb;
  logic bus_ack;
  logic [31:0] bus_rdata;
  logic out_valid;
  logic out_ready;
  logic [31:0] wb_data;
  logic [4:0] wb_rd;
  logic wb_en;
  logic mem_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(255), .W_RADDR(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .alu_result(alu_result),
    .store_data(store_data), .rd_in(rd_in),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_en(wb_en), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W_OPCODE-1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] sd,
                      input logic [4:0] rd);
    in_valid = 1'b1;
    mem_op = op;
    alu_result = a;
    store_data = sd;
    rd_in = rd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    mem_op = OP_ADD;
    alu_result = '0;
    store_data = '0;
    rd_in = '0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, bus_req, bus_we, bus_wstrb, wb_en, mem_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0",
        {out_valid, bus_req, bus_we, bus_wstrb, wb_en, mem_err});
    end
    n_checks++;
    if (wb_data !== 32'd0 || wb_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_wb: got %h/%0d expected 0/0", wb_data, wb_rd);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_alu();
    send(OP_ADD, 32'h0000_0005, 32'h0, 5'd3);
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'd5 || wb_rd !== 5'd3 || wb_en !== 1'b1 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_add: got v=%b d=%h rd=%0d en=%b err=%b expected 1 5 3 1 0",
        out_valid, wb_data, wb_rd, wb_en, mem_err);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_lb();
    send(OP_LB, 32'h0100_0003, 32'h0, 5'd5);
    n_checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h0100_0000 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_req: got req=%b we=%b addr=%h rdy=%b expected 1 0 01000000 0",
        bus_req, bus_we, bus_addr, in_ready);
    end
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_wait: got v=%b req=%b expected 0 1", out_valid, bus_req);
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h80FF_FFFF;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || wb_en !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_data: got v=%b d=%h en=%b req=%b expected 1 ffffff80 1 0",
        out_valid, wb_data, wb_en, bus_req);
    end
    tick();
  endtask

  task automatic test_lh_lhu();
    send(OP_LH, 32'h0000_0002, 32'h0, 5'd9);
    bus_ack = 1'b1;
    bus_rdata = 32'h8001_1234;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (wb_data !== 32'hFFFF_8001 || wb_en !== 1'b1) begin
      n_fail++;
      $display("FAIL lh_sext: got %h en=%b expected ffff8001 1", wb_data, wb_en);
    end
    tick();
    send(OP_LHU, 32'h0000_0002, 32'h0, 5'd9);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (wb_data !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lhu_zext: got %h expected 00008001", wb_data);
    end
    tick();
    send(OP_LBU, 32'h0000_0001, 32'h0, 5'd9);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (wb_data !== 32'h0000_0012) begin
      n_fail++;
      $display("FAIL lbu_zext: got %h expected 00000012", wb_data);
    end
    tick();
  endtask

  task automatic test_lw_rd0();
    send(OP_LW, 32'h0000_0010, 32'h0, 5'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'h1234_5678 || wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_rd0: got v=%b d=%h en=%b expected 1 12345678 0",
        out_valid, wb_data, wb_en);
    end
    tick();
  endtask

  task automatic test_stores();
    send(OP_SH, 32'h0200_0002, 32'h0000_BEEF, 5'd7);
    n_checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wstrb !== 4'b1100 || bus_wdata !== 32'hBEEF_BEEF || bus_addr !== 32'h0200_0000) begin
      n_fail++;
      $display("FAIL sh_bus: got req=%b we=%b strb=%b wd=%h a=%h expected 1 1 1100 beefbeef 02000000",
        bus_req, bus_we, bus_wstrb, bus_wdata, bus_addr);
    end
    tick();
    n_checks++;
    if (bus_wstrb !== 4'b1100 || bus_wdata !== 32'hBEEF_BEEF) begin
      n_fail++;
      $display("FAIL sh_stable: got strb=%b wd=%h expected 1100 beefbeef", bus_wstrb, bus_wdata);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_en !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_wb: got v=%b en=%b err=%b expected 1 0 0", out_valid, wb_en, mem_err);
    end
    tick();
    send(OP_SB, 32'h0000_0001, 32'h0000_00A5, 5'd7);
    n_checks++;
    if (bus_wstrb !== 4'b0010 || bus_wdata !== 32'hA5A5_A5A5 || bus_we !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_bus: got strb=%b wd=%h we=%b expected 0010 a5a5a5a5 1",
        bus_wstrb, bus_wdata, bus_we);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    send(OP_SW, 32'h0000_0008, 32'hCAFE_F00D, 5'd7);
    n_checks++;
    if (bus_wstrb !== 4'b1111 || bus_wdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL sw_bus: got strb=%b wd=%h expected 1111 cafef00d", bus_wstrb, bus_wdata);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    send(OP_LW, 32'h0300_0001, 32'h0, 5'd4);
    n_checks++;
    if (bus_req !== 1'b0 || out_valid !== 1'b1 || mem_err !== 1'b1 || wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_misal: got req=%b v=%b err=%b en=%b expected 0 1 1 0",
        bus_req, out_valid, mem_err, wb_en);
    end
    tick();
    send(OP_SH, 32'h0000_0003, 32'h0, 5'd4);
    n_checks++;
    if (bus_req !== 1'b0 || mem_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_misal: got req=%b err=%b expected 0 1", bus_req, mem_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    send(OP_LW, 32'h0000_0040, 32'h0, 5'd2);
    cnt = 0;
    while (bus_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 255) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d req cycles expected 255", cnt);
    end
    n_checks++;
    if (out_valid !== 1'b1 || mem_err !== 1'b1 || wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: got v=%b err=%b en=%b expected 1 1 0",
        out_valid, mem_err, wb_en);
    end
    out_ready = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || mem_err !== 1'b1 || wb_data !== 32'd0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: got v=%b err=%b d=%h req=%b expected 1 1 0 0",
        out_valid, mem_err, wb_data, bus_req);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    send(OP_ADD, 32'd33, 32'h0, 5'd6);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rdy: got %b expected 0", in_ready);
    end
    in_valid = 1'b1;
    alu_result = 32'd44;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'd33 || wb_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%b d=%0d rd=%0d expected 1 33 6",
        out_valid, wb_data, wb_rd);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'd44) begin
      n_fail++;
      $display("FAIL stall_next: got v=%b d=%0d expected 1 44", out_valid, wb_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send(OP_SUB, 32'd11, 32'h0, 5'd1);
    in_valid = 1'b1;
    mem_op = OP_OR;
    alu_result = 32'd22;
    rd_in = 5'd2;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'd11 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b d=%0d rdy=%b expected 1 11 1",
        out_valid, wb_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'd22 || wb_rd !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b d=%0d rd=%0d expected 1 22 2",
        out_valid, wb_data, wb_rd);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    send(OP_LW, 32'h0000_0080, 32'h0, 5'd8);
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_req: got %b expected 1", bus_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid: got req=%b v=%b rdy=%b expected 0 0 1",
        bus_req, out_valid, in_ready);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack: got v=%b req=%b expected 0 0", out_valid, bus_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lh_lhu();
    test_lw_rd0();
    test_stores();
    test_misaligned();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
